// File: rtl/bcd_ctrl_pkg.sv
// Shared constants for the BCD display controller: FSM encoding, datapath widths
// and active-low seven-segment glyphs ({g,f,e,d,c,b,a}).
package bcd_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int BCD_DIGITS = 10;
    localparam int BIN_W      = 32;
    localparam int SHIFT_W    = 72;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; dash overrides blank,
// and non-decimal codes are shown blank.
module seg7_decoder
    import bcd_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Two-requester binary-to-BCD converter (1 bit per cycle double-dabble) that holds
// the last result and scans it onto a multiplexed seven-segment display.
module bcd_display_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        busy,
    output logic [39:0] bcd_out,
    output logic        bcd_valid,
    output logic        overflow,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  dbg_state
);

    localparam int REF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               rr_ptr;
    logic               grant_a;
    logic               grant_b;
    logic [SHIFT_W-1:0] sreg;
    logic [SHIFT_W-1:0] sreg_adj;
    logic [4:0]         bit_cnt;
    logic               ovf_calc;

    logic [39:0]        disp_bcd;
    logic               disp_ovf;
    logic [REF_W-1:0]   ref_cnt;
    logic [2:0]         dig_idx;
    logic [2:0]         idx_nxt;
    logic [7:0]         lz_mask;
    logic [6:0]         seg_nxt;
    logic               ref_wrap;

    // Handshake: a transfer happens on any clk edge where x_valid && x_ready;
    // x_ready is only ever raised in IDLE and only for the granted requester.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (a_valid && b_valid) begin
                grant_a = (rr_ptr == RR_A);
                grant_b = (rr_ptr == RR_B);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_a || grant_b) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_ready   = grant_a;
        b_ready   = grant_b;
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // Add-3 correction on every BCD nibble before the shift; no inter-nibble carry.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sreg[BIN_W + 4*i +: 4] >= 4'd5) begin
                sreg_adj[BIN_W + 4*i +: 4] = sreg[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        ovf_calc = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= NUM_DIGITS && sreg[BIN_W + 4*i +: 4] != 4'd0) begin
                ovf_calc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= RR_A;
            sreg      <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (grant_a) begin
                rr_ptr  <= RR_B;
                sreg    <= {40'd0, a_data};
                bit_cnt <= '0;
            end else if (grant_b) begin
                rr_ptr  <= RR_A;
                sreg    <= {40'd0, b_data};
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                sreg    <= {sreg_adj[SHIFT_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end else if (state == DONE) begin
                bcd_out   <= sreg[SHIFT_W-1:BIN_W];
                bcd_valid <= 1'b1;
                overflow  <= ovf_calc;
                disp_bcd  <= sreg[SHIFT_W-1:BIN_W];
                disp_ovf  <= ovf_calc;
            end
        end
    end

    assign ref_wrap = (ref_cnt == REF_W'(CLK_DIV - 1));
    assign idx_nxt  = (dig_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig_idx + 3'd1;

    // A digit is a leading zero when it and every higher displayed digit are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS) begin
                zero_above = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
                lz_mask[i] = zero_above && (i != 0);
            end
        end
    end

    seg7_decoder u_seg7 (
        .digit (disp_bcd[{idx_nxt, 2'b00} +: 4]),
        .blank (BLANK_LZ && lz_mask[idx_nxt]),
        .dash  (disp_ovf),
        .seg   (seg_nxt)
    );

    // an/seg are registered at the digit advance, so fresh data shows from the next digit on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            dig_idx <= '0;
            an      <= 8'hFE;
            seg     <= SEG_0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
            dig_idx <= idx_nxt;
            an      <= ~(8'd1 << idx_nxt);
            seg     <= seg_nxt;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: vector table for conversions and display,
// plus hand-written arbitration and mid-conversion reset sequences.
module tb_bcd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, busy, bcd_valid, overflow;
    logic [39:0] bcd_out;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [1:0]  dbg_state;
    logic        a_ready_nb, b_ready_nb, busy_nb, bcd_valid_nb, overflow_nb;
    logic [39:0] bcd_out_nb;
    logic [7:0]  an_nb;
    logic [6:0]  seg_nb;
    logic [1:0]  dbg_state_nb;

    typedef struct {
        logic        sel_b;
        logic [31:0] data;
        logic [39:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs[8];
    logic [6:0]  glyph[10];
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    bcd_display_ctrl #(.CLK_DIV(4), .NUM_DIGITS(8), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .overflow(overflow),
        .an(an), .seg(seg), .dbg_state(dbg_state)
    );

    bcd_display_ctrl #(.CLK_DIV(4), .NUM_DIGITS(8), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_nb),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_nb),
        .busy(busy_nb), .bcd_out(bcd_out_nb), .bcd_valid(bcd_valid_nb), .overflow(overflow_nb),
        .an(an_nb), .seg(seg_nb), .dbg_state(dbg_state_nb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_request(input logic sel_b, input logic [31:0] d, input logic [39:0] e);
        @(negedge clk);
        if (sel_b) begin
            b_valid = 1'b1;
            b_data  = d;
        end else begin
            a_valid = 1'b1;
            a_data  = d;
        end
        #1;
        check("ready_granted", sel_b ? b_ready : a_ready, 1);
        check("ready_other", sel_b ? a_ready : b_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp_q.push_back(e);
    endtask

    // Entered #1 after the accept edge; returns #1 after the bcd_valid edge
    // (or one cycle later when tail is set).
    task automatic wait_result(input logic exp_ovf, input bit tail);
        int          n;
        int          viol;
        logic [39:0] e;
        n    = 0;
        viol = 0;
        check("busy_after_accept", busy, 1);
        while (!bcd_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!bcd_valid && (a_ready || b_ready)) viol++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
        check("latency", n, 33);
        check("bcd_out", bcd_out, e);
        check("overflow", overflow, exp_ovf);
        check("ready_while_busy", viol, 0);
        if (tail) begin
            @(posedge clk);
            #1;
            check("bcd_valid_pulse", bcd_valid, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic check_scan(input logic [39:0] v, input logic ovf);
        logic [6:0] es[8];
        logic [6:0] en[8];
        logic [7:0] an_prev;
        logic [7:0] exp_an;
        logic       zero_above;
        int         idx;
        int         hold;
        zero_above = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'd0);
            en[i] = ovf ? 7'h3F : glyph[v[4*i +: 4]];
            es[i] = ovf ? 7'h3F : ((zero_above && i != 0) ? 7'h7F : glyph[v[4*i +: 4]]);
        end
        an_prev = an;
        hold    = 0;
        while (an == an_prev && hold < 20) begin
            @(posedge clk);
            #1;
            hold++;
        end
        check("scan_advance", hold < 20, 1);
        idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (an == ~(8'd1 << i)) idx = i;
        end
        check("an_onehot", idx >= 0, 1);
        if (idx >= 0) begin
            for (int k = 0; k < 8; k++) begin
                if (k > 0) begin
                    idx    = (idx + 1) % 8;
                    exp_an = ~(8'd1 << idx);
                    check("an_walk", an, exp_an);
                end
                check("seg_blank_lz", seg, es[idx]);
                check("seg_no_blank", seg_nb, en[idx]);
                an_prev = an;
                hold    = 0;
                while (an == an_prev && hold < 20) begin
                    @(posedge clk);
                    #1;
                    hold++;
                end
                check("an_hold", hold, 4);
            end
        end
    endtask

    initial begin
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;

        vecs[0] = '{1'b0, 32'd0,          40'h0000000000, 1'b0};
        vecs[1] = '{1'b0, 32'd12345678,   40'h0012345678, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFFFFFF,   40'h4294967295, 1'b1};
        vecs[3] = '{1'b1, 32'd42,         40'h0000000042, 1'b0};
        vecs[4] = '{1'b0, 32'd99999999,   40'h0099999999, 1'b0};
        vecs[5] = '{1'b1, 32'd100000000,  40'h0100000000, 1'b1};
        vecs[6] = '{1'b0, 32'd1000000000, 40'h1000000000, 1'b1};
        vecs[7] = '{1'b0, 32'd3,          40'h0000000003, 1'b0};

        // Reset state
        apply_reset();
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_bcd_out", bcd_out, 40'h0);
        check("rst_bcd_valid", bcd_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 7'h40);

        // Vector table: conversion, latency, overflow and scanned display
        for (int v = 0; v < 8; v++) begin
            do_request(vecs[v].sel_b, vecs[v].data, vecs[v].exp_bcd);
            wait_result(vecs[v].exp_ovf, 1'b1);
            check_scan(vecs[v].exp_bcd, vecs[v].exp_ovf);
        end

        // Round-robin arbitration from reset
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'd5;
        b_valid = 1'b1; b_data = 32'd9;
        #1;
        check("tie1_a_ready", a_ready, 1);
        check("tie1_b_ready", b_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        exp_q.push_back(40'h5);
        wait_result(1'b0, 1'b0);
        check("b_ready_after_a", b_ready, 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        exp_q.push_back(40'h9);
        wait_result(1'b0, 1'b1);

        @(negedge clk);
        a_valid = 1'b1; a_data = 32'd7;
        b_valid = 1'b1; b_data = 32'd3;
        #1;
        check("tie2_a_ready", a_ready, 1);
        check("tie2_b_ready", b_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        exp_q.push_back(40'h7);
        wait_result(1'b0, 1'b0);
        check("b_ready_after_a2", b_ready, 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        exp_q.push_back(40'h3);
        wait_result(1'b0, 1'b1);

        // Asynchronous reset part-way through a conversion
        do_request(1'b0, 32'd87654321, 40'h0087654321);
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_reset", busy, 1);
        check("bcd_out_before_reset", bcd_out, 40'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_bcd_valid", bcd_valid, 0);
        check("async_bcd_out", bcd_out, 40'h0);
        check("async_an", an, 8'hFE);
        check("async_seg", seg, 7'h40);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_request(1'b1, 32'd2024, 40'h0000002024);
        wait_result(1'b0, 1'b1);
        check_scan(40'h0000002024, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
